// File: rtl/imm_decode_ctrl.sv
// Decode-stage controller: 2-entry skid FIFO between IF and ID/EX that tags each
// instruction with its immediate-generator mode and an illegal-opcode flag.
module imm_decode_ctrl #(
  parameter int         PC_W   = 32,
  parameter logic [2:0] TYPE_R = 3'b000,
  parameter logic [2:0] TYPE_I = 3'b001,
  parameter logic [2:0] TYPE_S = 3'b010,
  parameter logic [2:0] TYPE_B = 3'b011,
  parameter logic [2:0] TYPE_U = 3'b100,
  parameter logic [2:0] TYPE_J = 3'b101
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [PC_W-1:0] out_pc,
  output logic [2:0]      out_mode,
  output logic            out_illegal,
  output logic [1:0]      occupancy
);

  logic [31:0]     instr_q [2];
  logic [PC_W-1:0] pc_q    [2];
  logic [2:0]      mode_q  [2];
  logic            ill_q   [2];
  logic            wr_ptr_q, wr_ptr_d;
  logic            rd_ptr_q, rd_ptr_d;
  logic [1:0]      count_q, count_d;

  logic       push, pop;
  logic [2:0] dec_mode;
  logic       dec_illegal;

  assign in_ready  = (count_q != 2'd2) & ~flush;
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign occupancy = count_q;

  // Head entry is already registered; gating with out_valid zeroes it when empty.
  assign out_instr   = out_valid ? instr_q[rd_ptr_q] : '0;
  assign out_pc      = out_valid ? pc_q[rd_ptr_q]    : '0;
  assign out_mode    = out_valid ? mode_q[rd_ptr_q]  : TYPE_R;
  assign out_illegal = out_valid & ill_q[rd_ptr_q];

  always_comb begin
    dec_mode    = TYPE_R;
    dec_illegal = 1'b0;
    case (in_instr[6:0])
      7'b0110111, 7'b0010111: dec_mode = TYPE_U;
      7'b1101111:             dec_mode = TYPE_J;
      7'b1100011:             dec_mode = TYPE_B;
      7'b0100011:             dec_mode = TYPE_S;
      7'b1100111, 7'b0000011, 7'b0010011,
      7'b1110011, 7'b0001111: dec_mode = TYPE_I;
      7'b0110011:             dec_mode = TYPE_R;
      default:                dec_illegal = 1'b1;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
        mode_q[i]  <= TYPE_R;
        ill_q[i]   <= 1'b0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) begin
        instr_q[wr_ptr_q] <= in_instr;
        pc_q[wr_ptr_q]    <= in_pc;
        mode_q[wr_ptr_q]  <= dec_mode;
        ill_q[wr_ptr_q]   <= dec_illegal;
      end
    end
  end

endmodule

// File: tb/tb_imm_decode_ctrl.sv
// Scoreboard bench for imm_decode_ctrl: reference FIFO of expected head entries,
// compared against the DUT outputs every cycle at the falling edge.
module tb_imm_decode_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, flush, out_valid, out_ready, out_illegal;
  logic [31:0] in_instr, out_instr, in_pc, out_pc;
  logic [2:0]  out_mode;
  logic [1:0]  occupancy;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [2:0]  mode;
    logic        ill;
  } entry_t;

  entry_t sb_q[$];
  int     checks   = 0;
  int     failures = 0;

  imm_decode_ctrl #(.PC_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_mode(out_mode), .out_illegal(out_illegal),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic entry_t model_decode(input logic [31:0] instr, input logic [31:0] pc);
    entry_t e;
    e.instr = instr;
    e.pc    = pc;
    e.ill   = 1'b0;
    case (instr[6:0])
      7'h37, 7'h17:                      e.mode = 3'b100;
      7'h6F:                             e.mode = 3'b101;
      7'h63:                             e.mode = 3'b011;
      7'h23:                             e.mode = 3'b010;
      7'h67, 7'h03, 7'h13, 7'h73, 7'h0F: e.mode = 3'b001;
      7'h33:                             e.mode = 3'b000;
      default: begin e.mode = 3'b000; e.ill = 1'b1; end
    endcase
    return e;
  endfunction

  task automatic check_outputs();
    logic exp_valid;
    exp_valid = (sb_q.size() != 0);
    chk("out_valid", out_valid, exp_valid);
    chk("in_ready", in_ready, (sb_q.size() < 2) && !flush);
    chk("occupancy", occupancy, sb_q.size());
    if (exp_valid) begin
      chk("head_instr", out_instr, sb_q[0].instr);
      chk("head_pc", out_pc, sb_q[0].pc);
      chk("head_mode", out_mode, sb_q[0].mode);
      chk("head_illegal", out_illegal, sb_q[0].ill);
    end else begin
      chk("idle_outs", {out_instr, out_pc}, 64'h0);
      chk("idle_mode_ill", {out_mode, out_illegal}, 4'h0);
    end
  endtask

  // One clock cycle: drive, check at negedge, update model at posedge.
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic rdy, input logic fl);
    logic push, pop;
    in_valid = v; in_instr = ins; in_pc = pc; out_ready = rdy; flush = fl;
    @(negedge clk);
    check_outputs();
    push = v && (sb_q.size() < 2) && !fl;
    pop  = (sb_q.size() != 0) && rdy;
    @(posedge clk);
    if (fl) sb_q.delete();
    else begin
      if (pop)  void'(sb_q.pop_front());
      if (push) sb_q.push_back(model_decode(ins, pc));
    end
    #1;
  endtask

  logic [31:0] ops [12];

  initial begin
    ops = '{32'h00500093, 32'h00112023, 32'h00208463, 32'h123450B7, 32'h00001297,
            32'h008000EF, 32'h002081B3, 32'h00008067, 32'h0000A103, 32'h00000073,
            32'h0000000F, 32'h0000007F};
    rst_n = 1'b0; in_valid = 0; in_instr = 0; in_pc = 0; flush = 0; out_ready = 0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_occupancy", occupancy, 2'd0);
    chk("rst_out_mode", out_mode, 3'b000);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step(0, 0, 0, 1, 0);

    // single addi, then drain
    step(1, 32'h00500093, 32'h100, 1, 0);
    chk("addi_mode", out_mode, 3'b001);
    chk("addi_pc", out_pc, 32'h100);
    step(0, 0, 0, 1, 0);
    chk("addi_drained", out_valid, 1'b0);

    // stall fills to 2, head held stable
    step(1, 32'h00112023, 32'h200, 0, 0);
    step(1, 32'h00208463, 32'h204, 0, 0);
    chk("full_occ", occupancy, 2'd2);
    chk("full_in_ready", in_ready, 1'b0);
    step(1, 32'h00000033, 32'h208, 0, 0);
    chk("stall_mode_held", out_mode, 3'b010);
    step(0, 0, 0, 1, 0);
    chk("beq_next", out_mode, 3'b011);
    step(0, 0, 0, 1, 0);

    // back-to-back stream lui/jal/add
    step(1, 32'h123450B7, 32'h300, 1, 0);
    chk("stream_occ0", occupancy, 2'd1);
    step(1, 32'h008000EF, 32'h304, 1, 0);
    chk("stream_jal", out_mode, 3'b101);
    step(1, 32'h002081B3, 32'h308, 1, 0);
    chk("stream_add", out_mode, 3'b000);
    chk("stream_occ", occupancy, 2'd1);
    step(0, 0, 0, 1, 0);

    // flush with simultaneous push and pop
    step(1, 32'h00500093, 32'h400, 0, 0);
    step(1, 32'h00112023, 32'h404, 0, 0);
    step(1, 32'h00208463, 32'h408, 1, 1);
    chk("flush_occ", occupancy, 2'd0);
    chk("flush_valid", out_valid, 1'b0);
    step(0, 0, 0, 1, 0);

    // illegal opcode, then reset mid-stall
    step(1, 32'h0000007F, 32'h500, 0, 0);
    chk("illegal_flag", out_illegal, 1'b1);
    step(1, 32'h00500093, 32'h504, 0, 0);
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    chk("midrst_valid", out_valid, 1'b0);
    chk("midrst_occ", occupancy, 2'd0);
    chk("midrst_outs", {out_instr, out_pc, out_mode, out_illegal}, 68'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    in_valid = 0;
    step(0, 0, 0, 0, 0);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 3) != 0, ops[$urandom_range(0, 11)], $urandom,
           $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
    end
    in_valid = 0;
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
